// File: rtl/cf_job_sched_pkg.sv
// ---------------------------------------------------------------------------
// cf_sched_pkg
// Shared definitions for the job scheduler and the control-flow engine:
// scheduler state encoding, response status codes and engine command codes.
// No ports (package).
// ---------------------------------------------------------------------------
package cf_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_RESP  = 3'd5
    } sched_state_t;

    typedef enum logic [1:0] {
        RESP_OK      = 2'b00,
        RESP_ERR     = 2'b01,
        RESP_TIMEOUT = 2'b10
    } resp_status_t;

    // Engine command codes (the engine decodes the same values).
    localparam logic [2:0] CMD_NOP  = 3'b000;
    localparam logic [2:0] CMD_LOAD = 3'b001;
    localparam logic [2:0] CMD_PROC = 3'b010;

    localparam int DATA_W = 16;

endpackage

// File: rtl/cf_job_sched_if.sv
// ---------------------------------------------------------------------------
// cf_job_sched_if
// Bundles every scheduler-facing signal except clk/rst:
//   requester side : req_valid, req_data, req_ready
//   engine side    : eng_cmd, eng_data, eng_valid, eng_result, eng_ready, eng_error
//   response side  : resp_valid, resp_ready, resp_id, resp_data, resp_status
//   status         : busy, jobs_done
// Modport slave is the scheduler; modport master is everything around it.
// ---------------------------------------------------------------------------
interface cf_job_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0][15:0]   req_data;
    logic [NUM_REQ-1:0]         req_ready;

    logic [2:0]                 eng_cmd;
    logic [15:0]                eng_data;
    logic                       eng_valid;
    logic [15:0]                eng_result;
    logic                       eng_ready;
    logic                       eng_error;

    logic                       resp_valid;
    logic                       resp_ready;
    logic [ID_W-1:0]            resp_id;
    logic [15:0]                resp_data;
    logic [1:0]                 resp_status;

    logic                       busy;
    logic [15:0]                jobs_done;

    modport slave (
        input  req_valid, req_data, eng_result, eng_ready, eng_error, resp_ready,
        output req_ready, eng_cmd, eng_data, eng_valid,
               resp_valid, resp_id, resp_data, resp_status, busy, jobs_done
    );

    modport master (
        output req_valid, req_data, eng_result, eng_ready, eng_error, resp_ready,
        input  req_ready, eng_cmd, eng_data, eng_valid,
               resp_valid, resp_id, resp_data, resp_status, busy, jobs_done
    );
endinterface

// File: rtl/cf_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cf_rr_arbiter
// Purely combinational round-robin pick: the first set bit of req found when
// scanning upward from rr_ptr with wrap-around.
//   req       in  NUM_REQ : request vector
//   rr_ptr    in  ID_W    : index with the highest priority this cycle
//   grant     out NUM_REQ : one-hot winner (all zero when no request)
//   grant_idx out ID_W    : index of the winner (0 when no request)
//   any_req   out 1       : at least one request present
// The pointer itself is owned and advanced by the caller.
// ---------------------------------------------------------------------------
module cf_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_req
);

    assign any_req = |req;

    always_comb begin
        logic          found;
        logic [ID_W:0] idx;
        found     = 1'b0;
        idx       = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit so rr_ptr + k cannot overflow before the wrap.
            idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!found && req[idx[ID_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = idx[ID_W-1:0];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
            assign grant[gi] = any_req && (grant_idx == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/cf_job_sched.sv
// ---------------------------------------------------------------------------
// cf_job_sched
// Round-robin job scheduler in front of one control-flow engine. Grants one
// requester, loads its operand into the engine (two LOAD cycles), waits for
// the result/error with a watchdog, and returns a tagged response.
//   clk  in : clock
//   rst  in : synchronous active-high reset (engine must share it)
//   bus     : cf_job_sched_if.slave (requests, engine, response, status)
// req_ready is combinational; every other output is registered.
// ---------------------------------------------------------------------------
module cf_job_sched
    import cf_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic          clk,
    input  logic          rst,
    cf_job_sched_if.slave bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    sched_state_t       state_reg, state_next;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [15:0]        op_reg, op_next;
    logic [ID_W-1:0]    id_reg;
    logic [CNT_W-1:0]   wait_cnt_reg;

    logic [2:0]         eng_cmd_reg;
    logic [15:0]        eng_data_reg;
    logic               eng_valid_reg;
    logic               resp_valid_reg;
    logic [ID_W-1:0]    resp_id_reg;
    logic [15:0]        resp_data_reg;
    resp_status_t       resp_status_reg, status_next;
    logic               busy_reg;
    logic [15:0]        jobs_done_reg;

    logic [NUM_REQ-1:0] arb_grant;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic               grant_ok;
    logic               status_set;
    logic               result_take;
    logic               eng_load;

    cf_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req       (bus.req_valid),
        .rr_ptr    (rr_ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    always_comb begin
        state_next  = state_reg;
        grant_ok    = 1'b0;
        status_set  = 1'b0;
        status_next = RESP_OK;
        result_take = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Only start a job on an engine that is idle and healthy.
                if (arb_any && bus.eng_ready && !bus.eng_error) begin
                    grant_ok   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.eng_error) begin
                    status_set  = 1'b1;
                    status_next = RESP_ERR;
                    state_next  = ST_RESP;
                end else if (bus.eng_ready) begin
                    status_set  = 1'b1;
                    result_take = 1'b1;
                    status_next = RESP_OK;
                    state_next  = ST_RESP;
                end else if (wait_cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
                    status_set  = 1'b1;
                    status_next = RESP_TIMEOUT;
                    state_next  = ST_DRAIN;
                end
            end
            // Let the hung job finish so the engine is back in IDLE before
            // the next grant; its result is thrown away.
            ST_DRAIN: begin
                if (bus.eng_ready || bus.eng_error) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // On the grant cycle the operand register is not loaded yet, so the
    // engine data path takes it straight from the winning requester.
    assign op_next  = grant_ok ? bus.req_data[arb_idx] : op_reg;
    assign eng_load = (state_next == ST_ISSUE) || (state_next == ST_LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            rr_ptr_reg      <= '0;
            op_reg          <= '0;
            id_reg          <= '0;
            wait_cnt_reg    <= '0;
            eng_cmd_reg     <= CMD_NOP;
            eng_data_reg    <= '0;
            eng_valid_reg   <= 1'b0;
            resp_valid_reg  <= 1'b0;
            resp_id_reg     <= '0;
            resp_data_reg   <= '0;
            resp_status_reg <= RESP_OK;
            busy_reg        <= 1'b0;
            jobs_done_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (grant_ok) begin
                op_reg     <= op_next;
                id_reg     <= arb_idx;
                rr_ptr_reg <= (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
            // Held at zero outside WAIT, so it is zero on every WAIT entry;
            // it stops before reaching TIMEOUT_CYC and cannot wrap.
            if (state_reg != ST_WAIT) begin
                wait_cnt_reg <= '0;
            end else if (state_next == ST_WAIT) begin
                wait_cnt_reg <= wait_cnt_reg + 1'b1;
            end
            if (status_set) begin
                resp_status_reg <= status_next;
                resp_data_reg   <= result_take ? bus.eng_result : '0;
            end
            if (state_next == ST_RESP && state_reg != ST_RESP) begin
                resp_id_reg <= id_reg;
            end
            eng_cmd_reg    <= eng_load ? CMD_LOAD : CMD_NOP;
            eng_valid_reg  <= eng_load;
            eng_data_reg   <= eng_load ? op_next : '0;
            resp_valid_reg <= (state_next == ST_RESP);
            busy_reg       <= (state_next != ST_IDLE);
            if (state_reg == ST_RESP && bus.resp_ready) begin
                jobs_done_reg <= jobs_done_reg + 1'b1;
            end
        end
    end

    assign bus.req_ready   = (grant_ok && !rst) ? arb_grant : '0;
    assign bus.eng_cmd     = eng_cmd_reg;
    assign bus.eng_data    = eng_data_reg;
    assign bus.eng_valid   = eng_valid_reg;
    assign bus.resp_valid  = resp_valid_reg;
    assign bus.resp_id     = resp_id_reg;
    assign bus.resp_data   = resp_data_reg;
    assign bus.resp_status = resp_status_reg;
    assign bus.busy        = busy_reg;
    assign bus.jobs_done   = jobs_done_reg;

endmodule

// File: doc/cf_job_sched.md
# cf_job_sched

Job scheduler for the 16-bit control-flow processing engine: accepts jobs from `NUM_REQ` requesters, picks one with a round-robin arbiter, and runs the engine's load/process command sequence. It collects the engine's result or error and returns it on a single response channel tagged with the requester ID. A watchdog covers a hung engine. It sits between the requester-side job queues and one engine instance, and is the only block that drives the engine's `cmd`, `data_in` and `valid_in`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: requester ID width, equal to $clog2(NUM_REQ).
- `TIMEOUT_CYC`, default 64: maximum number of WAIT cycles before a job is declared timed out, ≥2.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ: per-requester job valid.
- `req_data`  in  NUM_REQ×16: per-requester job operand.
- `req_ready`  out  NUM_REQ: one-hot grant/accept, asserted for one cycle.
- `eng_cmd`  out  3: to engine `cmd`.
- `eng_data`  out  16: to engine `data_in`.
- `eng_valid`  out  1: to engine `valid_in`.
- `eng_result`  in  16: from engine `data_out`.
- `eng_ready`  in  1: from engine `ready_out`.
- `eng_error`  in  1: from engine `error_out`.
- `resp_valid`  out  1: response valid.
- `resp_ready`  in  1: response accept.
- `resp_id`  out  ID_W: ID of the requester that owns the response.
- `resp_data`  out  16: result; 0 unless status is OK.
- `resp_status`  out  2: 00 OK, 01 ERR, 10 TIMEOUT.
- `busy`  out  1: high in any state other than IDLE.
- `jobs_done`  out  16: count of accepted responses; wraps at 0xFFFF→0.

## Operation
State machine: IDLE, ISSUE, LOAD, WAIT, DRAIN, RESP.
- **IDLE**
  - Grant condition: any `req_valid`, `eng_ready`=1 and `eng_error`=0.
  - Winner: first requester with `req_valid` set, searching from `rr_ptr` upward with wrap.
  - On grant: `req_ready[winner]`=1 for that cycle; latch its data and ID; `rr_ptr` ← winner+1 (mod NUM_REQ); go to ISSUE.
- **ISSUE**: `eng_cmd`=001, `eng_valid`=1, `eng_data`=latched operand. Go to LOAD. The engine moves IDLE→READ.
- **LOAD**: same drive as ISSUE. The engine captures the operand and moves to PROCESS. Go to WAIT.
- **WAIT**: `eng_cmd`=000, `eng_valid`=0, wait counter increments every cycle. Checks in priority order:
  1. `eng_error` → status ERR, go to RESP.
  2. Else `eng_ready` (engine in WRITE) → latch `eng_result`, status OK, go to RESP.
  3. Else counter = TIMEOUT_CYC−1 → status TIMEOUT, go to DRAIN.
- **DRAIN**: hold the engine at NOP until `eng_ready` or `eng_error`, then go to RESP. The engine result is discarded.
- **RESP**: `resp_valid`=1 with id, data and status held stable. On `resp_ready`: increment `jobs_done`, go to IDLE. No grant is issued while a response is pending.
- In every state except ISSUE and LOAD: `eng_cmd`=000, `eng_valid`=0, `eng_data`=0.
- The wait counter is cleared on entry to WAIT. It is wide enough for TIMEOUT_CYC and never wraps.

## Timing
- Reset values: all outputs 0, state IDLE, `rr_ptr` 0, `jobs_done` 0, wait counter 0.
- Reset asserted mid-job: the job is dropped with no response. The engine must be reset on the same cycle (engine `rst_n` = ~`rst`).
- Cycle at which the IDLE grant occurs = cycle 0.
  - Cycle 1: ISSUE. Cycle 2: LOAD. Cycle 3: first WAIT cycle.
  - Earliest `resp_valid` is the cycle after the engine's WRITE or ERROR cycle.
- Minimum spacing between grants is 5 cycles.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.
- Simultaneous `eng_error` and `eng_ready` in WAIT: ERR wins.
- Requesters must hold `req_valid` and `req_data` stable until granted.

## Structure
- Package `cf_sched_pkg`:
  - `sched_state_t` enum.
  - `resp_status_t` enum: OK, ERR, TIMEOUT.
  - Engine command constants: `CMD_NOP`=3'b000, `CMD_LOAD`=3'b001, `CMD_PROC`=3'b010.
  - Shared with the engine.
- Sub-module `cf_rr_arbiter`, parameterised on NUM_REQ:
  - Inputs: request vector, `rr_ptr`.
  - Outputs: one-hot grant, grant index, any-request flag.
  - Purely combinational. Pointer update stays in the scheduler.

## Test plan
- **Single job:** after reset, requester 0 sends 0x0010 → OK result 0x0020, resp_id 0, `jobs_done`=1.
- **Engine error:** requester 2 sends 0x7FF8 → engine ERROR after 8 PROCESS cycles → status ERR, `resp_data` 0x0000, resp_id 2.
- **Round-robin fairness:** all 4 requesters hold `req_valid` with `resp_ready`=1 → grant order 0,1,2,3,0; each `req_ready` pulse lasts one cycle.
- **Response back-pressure:** `resp_ready` held low 5 cycles → `resp_valid`, id, data and status stay stable; no `req_ready`; `jobs_done` increments only on the accept cycle.
- **Timeout:** TIMEOUT_CYC=4, job 0x0010 → status TIMEOUT after 4 WAIT cycles, DRAIN until engine WRITE, next grant only after the engine returns to IDLE.
- **Reset mid-WAIT:** assert `rst` for 1 cycle → next cycle all outputs 0, no response emitted; a fresh job then completes OK.
